// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   NREQ     : number of requesters
//   IDW      : width of a requester index
//   state_t  : 1-bit FSM encoding (ST_IDLE / ST_GRANT)
//   LAST_RST : "last owner" value after reset, so requester 0 wins first
package rr_arbiter4_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [IDW-1:0] LAST_RST = 2'b11;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req     : request lines, bit i is requester i
//   done    : one-cycle release pulse from the current owner
//   gnt     : registered one-hot grant
//   gnt_id  : registered index of the current or last owner
//   busy    : a grant is active
//   timeout : one-cycle pulse when a grant was revoked by the hold limit
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );

endinterface

// File: rtl/rr_arbiter4_dec2to4.sv
// Purely combinational 2-to-4 one-hot decoder.
//   idx    : binary index
//   onehot : 00->0001, 01->0010, 10->0100, 11->1000
module dec2to4
  import rr_arbiter4_pkg::*;
(
  input  logic [IDW-1:0]  idx,
  output logic [NREQ-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_dec
      assign onehot[gi] = (idx == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold-time limit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter4_if.slave (req, done in; gnt, gnt_id, busy, timeout out)
// Parameters:
//   MAX_HOLD : maximum grant length in cycles, 0 disables the limit
//   CW       : hold counter width, 2**CW must exceed MAX_HOLD
// All outputs come straight from flops.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter4_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  // Counter value seen during the final allowed grant cycle.
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD != 0) ? CW'(MAX_HOLD - 1) : '0;

  state_t          state_reg,    state_next;
  logic [NREQ-1:0] gnt_reg,      gnt_next;
  logic [IDW-1:0]  gnt_id_reg,   gnt_id_next;
  logic            busy_reg,     busy_next;
  logic            timeout_reg,  timeout_next;
  logic [IDW-1:0]  last_reg,     last_next;
  logic [CW-1:0]   hold_cnt_reg, hold_cnt_next;

  logic            win_valid;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  scan_idx;
  logic [NREQ-1:0] win_onehot;

  logic            rel_dropped;
  logic            rel_expired;
  logic            rel_now;

  // Round-robin scan: last+1, last+2, last+3, last (index wraps in IDW bits).
  always_comb begin
    win_valid = 1'b0;
    win_id    = last_reg;
    scan_idx  = last_reg;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = last_reg + IDW'(k);
      if (!win_valid && bus.req[scan_idx]) begin
        win_valid = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  dec2to4 u_dec (
    .idx    (win_id),
    .onehot (win_onehot)
  );

  assign rel_dropped = !bus.req[gnt_id_reg];
  assign rel_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
  assign rel_now     = bus.done || rel_dropped || rel_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      last_reg     <= LAST_RST;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      gnt_id_reg   <= gnt_id_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    busy_next     = busy_reg;
    timeout_next  = 1'b0;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        hold_cnt_next = '0;
        if (win_valid) begin
          state_next  = ST_GRANT;
          gnt_next    = win_onehot;
          gnt_id_next = win_id;
          busy_next   = 1'b1;
        end else begin
          gnt_next  = '0;
          busy_next = 1'b0;
        end
      end
      ST_GRANT: begin
        if (rel_now) begin
          state_next    = ST_IDLE;
          gnt_next      = '0;
          busy_next     = 1'b0;
          last_next     = gnt_id_reg;
          hold_cnt_next = '0;
          // done or a dropped request take precedence over the hold limit.
          timeout_next  = rel_expired && !bus.done && !rel_dropped;
        end else if (hold_cnt_reg != CNT_MAX) begin
          hold_cnt_next = hold_cnt_reg + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.busy    = busy_reg;
  assign bus.timeout = timeout_reg;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter that shares one downstream resource. It drives a registered one-hot grant plus a 2-bit grant index, and it holds each grant until the owner signals done, drops its request, or hits a hold-time limit. The one-hot grant comes from a 2-to-4 decode of the winner index, so it follows the team's standard decoder truth table (00→0001, 01→0010, 10→0100, 11→1000).

Parameters:
MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout
CW, 5, width of the hold counter; must satisfy 2^CW > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; bit i is requester i
done  input  1  one-cycle pulse from the current owner releasing the resource
gnt  output  4  registered one-hot grant; 0000 when no owner
gnt_id  output  2  registered index of the current or last owner
busy  output  1  high while a grant is active
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Interface: single clock clk. rst_n is asynchronous, active-low.
- Reset (async assert, sync-to-clk release):
  - state = IDLE, gnt = 0000, gnt_id = 00, busy = 0, timeout = 0, hold_cnt = 0.
  - last = 2'b11, so requester 0 has top priority after reset.
- State machine: IDLE and GRANT only. State encoding is registered and 1-bit.
- IDLE:
  - If req == 0000: stay in IDLE; all outputs hold their reset-like values, except gnt_id, which keeps the last owner.
  - If req != 0000: winner = the first set bit when scanning last+1, last+2, last+3, last (mod 4).
  - On the next edge: state = GRANT, gnt_id = winner, gnt = decode(winner), busy = 1, hold_cnt = 0.
  - Latency from req to gnt is exactly 1 cycle.
- GRANT:
  - hold_cnt increments every cycle and saturates at 2^CW - 1.
  - Release condition R = done OR (req[gnt_id] == 0) OR (MAX_HOLD != 0 AND hold_cnt == MAX_HOLD - 1).
  - On R, at the next edge: state = IDLE, gnt = 0000, busy = 0, last = gnt_id.
  - This gives one mandatory turnaround cycle with gnt = 0000 between any two grants, including back-to-back grants to different requesters.
  - If R is not true: gnt, gnt_id and busy hold.
- timeout:
  - Asserted for exactly the cycle after R when the release was caused only by the timeout term, i.e. done = 0 and req[gnt_id] = 1.
  - If done and the timeout term coincide, the release counts as done and timeout stays 0.
- done outside GRANT is ignored.
- Requests from non-owners during GRANT are ignored; they are arbitrated in the next IDLE cycle.
- Fairness: a requester that holds req high is granted within 3 other grants.
- Reset mid-grant: gnt, busy and timeout clear immediately and asynchronously; last returns to 11.
- No combinational path from inputs to outputs. All outputs are flops.

Decomposition:
- Shared header (`include file): NREQ = 4, state encodings ST_IDLE = 1'b0 and ST_GRANT = 1'b1, and the reset value LAST_RST = 2'b11.
- One sub-module, dec2to4: a purely combinational 2-to-4 one-hot decoder, instantiated on the winner index. Its output is registered into gnt in the parent.
- The round-robin priority scan stays inline in rr_arbiter4.

Test Plan:
1. Reset, then req = 0001 held and done pulsed 3 cycles after the grant:
   - gnt = 0001 and gnt_id = 00 one cycle after req.
   - Grant holds for 3 cycles.
   - Then gnt = 0000 and busy = 0.
2. req = 1111 held, done pulsed every grant:
   - Grant order is 0001, 0010, 0100, 1000, 0001.
   - Each grant is separated by exactly one gnt = 0000 cycle.
3. MAX_HOLD = 4, req = 0100 held, done never:
   - gnt = 0100 for exactly 4 cycles, then gnt = 0000 with timeout = 1 for 1 cycle.
   - The grant is re-issued to 0100 on the following cycle.
4. Owner drops req mid-grant (req 0010 → 0000 at grant cycle 2):
   - Release on the next edge, timeout = 0, last = 01.
   - A subsequent req = 0011 grants 0001 first.
5. done and the timeout term in the same cycle (MAX_HOLD = 2, done on grant cycle 2):
   - Single release, timeout stays 0.
6. rst_n pulsed low mid-grant (gnt = 1000), with no clock edge during the pulse:
   - gnt = 0000 and busy = 0 immediately.
   - After release with req = 1001, gnt = 0001 (priority reset to requester 0).
